// File: rtl/meter_pkg.sv
// Shared definitions for the toggle period meter: state encoding, default
// count width and the absolute-difference helper used by the lock logic.
package meter_pkg;

    // Matches the clock_count width of the LED clock divider.
    localparam int DEFAULT_WIDTH = 26;

    // Width of the absolute-difference helper; callers zero-extend into it.
    localparam int DIFF_W = 64;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARM     = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;

    // Unsigned |a - b|; operands are zero-extended so no overflow can occur.
    function automatic logic [DIFF_W-1:0] abs_diff(input logic [DIFF_W-1:0] a,
                                                   input logic [DIFF_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous level followed by a
// both-polarity edge detector. Reusable for buttons and similar inputs.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_in,
    output logic level_out,
    output logic edge_out
);

    logic sync_reg [SYNC_STAGES];
    logic prev_reg;

    // Synchronizer chain: stage 0 samples the raw input, later stages shift.
    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                // First stage captures the asynchronous input.
                always_ff @(posedge clock) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= async_in;
                end
            end else begin : g_rest
                // Later stages resolve metastability.
                always_ff @(posedge clock) begin
                    if (reset) sync_reg[gi] <= 1'b0;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Previous sample of the synchronized level for edge detection.
    always_ff @(posedge clock) begin
        if (reset) prev_reg <= 1'b0;
        else       prev_reg <= sync_reg[SYNC_STAGES-1];
    end

    assign level_out = sync_reg[SYNC_STAGES-1];
    assign edge_out  = sync_reg[SYNC_STAGES-1] ^ prev_reg;

endmodule

// File: rtl/toggle_period_meter.sv
// Measures the half-period of a slow toggling input in clock cycles, using
// the divider's clock_count encoding (edges N+1 cycles apart report N).
// Adds a sticky no-edge timeout and a stable-rate lock indicator.
module toggle_period_meter
    import meter_pkg::*;
#(
    parameter int               WIDTH       = DEFAULT_WIDTH,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] TIMEOUT     = {WIDTH{1'b1}},
    parameter int               MATCH_TOL   = 1,
    parameter int               LOCK_COUNT  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sig_in,
    output logic [WIDTH-1:0] half_period,
    output logic             period_valid,
    output logic             timeout,
    output logic             locked
);

    localparam int              MCW    = $clog2(LOCK_COUNT + 1);
    localparam logic [MCW-1:0]  LOCK_M = MCW'(LOCK_COUNT);

    logic             sig_level;
    logic             sig_edge;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] count_reg, count_next;
    logic [WIDTH-1:0] half_period_reg, half_period_next;
    logic             period_valid_reg, period_valid_next;
    logic             timeout_reg, timeout_next;
    logic             locked_reg, locked_next;
    logic [MCW-1:0]   match_cnt_reg, match_cnt_next;
    logic             first_reg, first_next;
    logic [WIDTH:0]   diff;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .async_in (sig_in),
        .level_out(sig_level),
        .edge_out (sig_edge)
    );

    // Distance between the new measurement and the previous one.
    assign diff = (WIDTH+1)'(abs_diff(DIFF_W'(count_reg), DIFF_W'(half_period_reg)));

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; enable low always returns to IDLE.
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    state_next = ARM;
                ARM:     if (sig_edge) state_next = MEASURE;
                MEASURE: if (!sig_edge && count_reg == TIMEOUT) state_next = ARM;
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath next values: counter, measurement, timeout and lock tracking.
    always_comb begin
        count_next        = count_reg;
        half_period_next  = half_period_reg;
        period_valid_next = 1'b0;
        timeout_next      = timeout_reg;
        match_cnt_next    = match_cnt_reg;
        first_next        = first_reg;
        locked_next       = (match_cnt_reg == LOCK_M);
        if (!enable) begin
            count_next     = '0;
            match_cnt_next = '0;
            locked_next    = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_next     = '0;
                    match_cnt_next = '0;
                    locked_next    = 1'b0;
                end
                ARM: begin
                    count_next = '0;
                    // The reference edge starts a fresh run with no predecessor.
                    if (sig_edge) first_next = 1'b1;
                end
                MEASURE: begin
                    if (sig_edge) begin
                        // An edge wins over a simultaneous timeout.
                        half_period_next  = count_reg;
                        period_valid_next = 1'b1;
                        timeout_next      = 1'b0;
                        count_next        = '0;
                        first_next        = 1'b0;
                        if (first_reg)
                            match_cnt_next = '0;
                        else if (diff <= (WIDTH+1)'(MATCH_TOL))
                            match_cnt_next = (match_cnt_reg == LOCK_M) ? LOCK_M
                                                                       : match_cnt_reg + MCW'(1);
                        else
                            match_cnt_next = '0;
                    end else if (count_reg == TIMEOUT) begin
                        timeout_next   = 1'b1;
                        locked_next    = 1'b0;
                        match_cnt_next = '0;
                        count_next     = '0;
                    end else begin
                        count_next = count_reg + WIDTH'(1);
                    end
                end
                default: begin
                    count_next = '0;
                end
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg        <= '0;
            half_period_reg  <= '0;
            period_valid_reg <= 1'b0;
            timeout_reg      <= 1'b0;
            locked_reg       <= 1'b0;
            match_cnt_reg    <= '0;
            first_reg        <= 1'b0;
        end else begin
            count_reg        <= count_next;
            half_period_reg  <= half_period_next;
            period_valid_reg <= period_valid_next;
            timeout_reg      <= timeout_next;
            locked_reg       <= locked_next;
            match_cnt_reg    <= match_cnt_next;
            first_reg        <= first_next;
        end
    end

    assign half_period  = half_period_reg;
    assign period_valid = period_valid_reg;
    assign timeout      = timeout_reg;
    assign locked       = locked_reg;

endmodule

// File: tb/tb_toggle_period_meter.sv
// Directed testbench for toggle_period_meter with TIMEOUT = 100.
module tb_toggle_period_meter;
    import meter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        sig_in = 1'b0;
    logic [25:0] half_period;
    logic        period_valid;
    logic        timeout;
    logic        locked;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    int cyc = 0;
    int last_tog = 0;
    logic rst_at_edge = 1'b1;
    logic locked_q = 1'b0;
    logic [25:0] hp_q = '0;
    int hp_err = 0;
    int pv_val[$];
    int pv_cyc[$];
    int lock_rise[$];
    int lock_fall[$];

    toggle_period_meter #(
        .TIMEOUT(26'd100)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sig_in      (sig_in),
        .half_period (half_period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .locked      (locked)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc = cyc + 1;
        rst_at_edge = reset;
    end

    // Event recorder: measurements, lock transitions, stray half_period changes.
    always @(negedge clock) begin
        if (period_valid) begin
            pv_val.push_back(int'(half_period));
            pv_cyc.push_back(cyc);
            $display("[%0d] period_valid half_period=%0d locked=%0b timeout=%0b",
                     cyc, half_period, locked, timeout);
        end
        if (locked && !locked_q) lock_rise.push_back(cyc);
        if (!locked && locked_q) lock_fall.push_back(cyc);
        if (!rst_at_edge && !period_valid && half_period !== hp_q) hp_err++;
        locked_q = locked;
        hp_q = half_period;
    end

    task automatic tog_gap(input int n);
        while ((cyc - last_tog) < n) @(negedge clock);
        sig_in = ~sig_in;
        last_tog = cyc;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0; sig_in = 1'b0;
        settle(3);
        assert_cnt++; if (half_period !== 26'd0) begin fail_cnt++; $display("FAIL reset_hp got=%0d exp=0", half_period); end
        assert_cnt++; if (period_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_pv got=%0b exp=0", period_valid); end
        assert_cnt++; if (timeout !== 1'b0) begin fail_cnt++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
        assert_cnt++; if (locked !== 1'b0) begin fail_cnt++; $display("FAIL reset_locked got=%0b exp=0", locked); end
        assert_cnt++; if (dut.state_reg !== IDLE) begin fail_cnt++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_reg, IDLE); end
        reset = 1'b0;
        enable = 1'b1;
        settle(4);
        assert_cnt++; if (dut.state_reg !== ARM) begin fail_cnt++; $display("FAIL enable_arm got=%0d exp=%0d", dut.state_reg, ARM); end
        $display("[%0d] reset done", cyc);
    endtask

    // Divider loopback with clock_count = 9: toggles every 10 cycles.
    task automatic test_loopback;
        int base;
        int lbase;
        base = pv_val.size();
        lbase = lock_rise.size();
        sig_in = ~sig_in; last_tog = cyc;      // reference edge
        for (int i = 0; i < 6; i++) tog_gap(10);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 6) begin fail_cnt++; $display("FAIL loop_count got=%0d exp=6", pv_val.size() - base); end
        for (int i = 0; i < 6 && base + i < pv_val.size(); i++) begin
            assert_cnt++; if (pv_val[base+i] !== 9) begin fail_cnt++; $display("FAIL loop_value[%0d] got=%0d exp=9", i, pv_val[base+i]); end
        end
        if (pv_val.size() - base >= 6) begin
            assert_cnt++; if (pv_cyc[base+5] - pv_cyc[base+4] !== 10) begin fail_cnt++; $display("FAIL loop_spacing got=%0d exp=10", pv_cyc[base+5] - pv_cyc[base+4]); end
            assert_cnt++;
            if (lock_rise.size() - lbase !== 1 || lock_rise[lock_rise.size()-1] !== pv_cyc[base+4] + 1) begin
                fail_cnt++; $display("FAIL loop_lock_rise got_rises=%0d exp_cycle=%0d", lock_rise.size() - lbase, pv_cyc[base+4] + 1);
            end
        end
        assert_cnt++; if (locked !== 1'b1) begin fail_cnt++; $display("FAIL loop_locked got=%0b exp=1", locked); end
    endtask

    // Alternating 11/10 spacing stays locked; a step to 21 drops and re-locks.
    task automatic test_jitter_step;
        int base;
        int fbase;
        int rbase;
        int exp_j[4] = '{10, 9, 10, 9};
        base = pv_val.size();
        fbase = lock_fall.size();
        tog_gap(11); tog_gap(10); tog_gap(11); tog_gap(10);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 4) begin fail_cnt++; $display("FAIL jitter_count got=%0d exp=4", pv_val.size() - base); end
        for (int i = 0; i < 4 && base + i < pv_val.size(); i++) begin
            assert_cnt++; if (pv_val[base+i] !== exp_j[i]) begin fail_cnt++; $display("FAIL jitter_value[%0d] got=%0d exp=%0d", i, pv_val[base+i], exp_j[i]); end
        end
        assert_cnt++; if (lock_fall.size() !== fbase || locked !== 1'b1) begin fail_cnt++; $display("FAIL jitter_locked falls=%0d locked=%0b exp falls=0 locked=1", lock_fall.size() - fbase, locked); end
        base = pv_val.size();
        rbase = lock_rise.size();
        for (int i = 0; i < 5; i++) tog_gap(21);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 5) begin fail_cnt++; $display("FAIL step_count got=%0d exp=5", pv_val.size() - base); end
        if (pv_val.size() - base >= 5) begin
            assert_cnt++; if (pv_val[base] !== 20 || pv_val[base+4] !== 20) begin fail_cnt++; $display("FAIL step_value got=%0d,%0d exp=20,20", pv_val[base], pv_val[base+4]); end
            assert_cnt++; if (lock_fall.size() - fbase !== 1 || lock_fall[lock_fall.size()-1] !== pv_cyc[base] + 1) begin fail_cnt++; $display("FAIL step_lock_drop falls=%0d exp_cycle=%0d", lock_fall.size() - fbase, pv_cyc[base] + 1); end
            assert_cnt++; if (lock_rise.size() - rbase !== 1 || lock_rise[lock_rise.size()-1] !== pv_cyc[base+4] + 1) begin fail_cnt++; $display("FAIL step_relock rises=%0d exp_cycle=%0d", lock_rise.size() - rbase, pv_cyc[base+4] + 1); end
        end
    endtask

    // Source stops: timeout fires once the counter has reached 100 with no edge.
    task automatic test_timeout;
        int base;
        int p;
        int t;
        base = pv_val.size();
        p = pv_cyc[pv_cyc.size()-1];
        for (int i = 0; i < 200 && !timeout; i++) @(negedge clock);
        t = cyc;
        assert_cnt++; if (timeout !== 1'b1) begin fail_cnt++; $display("FAIL timeout_set got=%0b exp=1", timeout); end
        assert_cnt++; if (t - p !== 101) begin fail_cnt++; $display("FAIL timeout_delay got=%0d exp=101", t - p); end
        #1;
        assert_cnt++; if (locked !== 1'b0) begin fail_cnt++; $display("FAIL timeout_locked got=%0b exp=0", locked); end
        assert_cnt++; if (dut.state_reg !== ARM) begin fail_cnt++; $display("FAIL timeout_state got=%0d exp=%0d", dut.state_reg, ARM); end
        assert_cnt++; if (half_period !== 26'd20 || pv_val.size() !== base) begin fail_cnt++; $display("FAIL timeout_retain hp=%0d new_pv=%0d exp hp=20 new_pv=0", half_period, pv_val.size() - base); end
        $display("[%0d] timeout asserted", t);
        settle(20);
        tog_gap(1);                             // arms only
        settle(6);
        assert_cnt++; if (timeout !== 1'b1 || pv_val.size() !== base) begin fail_cnt++; $display("FAIL timeout_arm timeout=%0b new_pv=%0d exp 1 and 0", timeout, pv_val.size() - base); end
        tog_gap(50);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 1 || half_period !== 26'd49) begin fail_cnt++; $display("FAIL timeout_recover new_pv=%0d hp=%0d exp 1 and 49", pv_val.size() - base, half_period); end
        assert_cnt++; if (timeout !== 1'b0) begin fail_cnt++; $display("FAIL timeout_clear got=%0b exp=0", timeout); end
    endtask

    // Edge exactly at counter == TIMEOUT, then back-to-back toggles.
    task automatic test_boundary;
        int base;
        base = pv_val.size();
        tog_gap(101);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 1 || half_period !== 26'd100) begin fail_cnt++; $display("FAIL boundary_value new_pv=%0d hp=%0d exp 1 and 100", pv_val.size() - base, half_period); end
        assert_cnt++; if (timeout !== 1'b0) begin fail_cnt++; $display("FAIL boundary_timeout got=%0b exp=0", timeout); end
        base = pv_val.size();
        tog_gap(10);
        tog_gap(1);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 2) begin fail_cnt++; $display("FAIL b2b_count got=%0d exp=2", pv_val.size() - base); end
        if (pv_val.size() - base >= 2) begin
            assert_cnt++; if (pv_val[base] !== 9 || pv_val[base+1] !== 0) begin fail_cnt++; $display("FAIL b2b_value got=%0d,%0d exp=9,0", pv_val[base], pv_val[base+1]); end
            assert_cnt++; if (pv_cyc[base+1] - pv_cyc[base] !== 1) begin fail_cnt++; $display("FAIL b2b_spacing got=%0d exp=1", pv_cyc[base+1] - pv_cyc[base]); end
        end
    endtask

    // enable dropped in the same cycle the edge is presented to the FSM.
    task automatic test_enable_drop;
        int base;
        for (int i = 0; i < 7; i++) tog_gap(10);
        settle(5);
        assert_cnt++; if (locked !== 1'b1 || half_period !== 26'd9) begin fail_cnt++; $display("FAIL drop_pre locked=%0b hp=%0d exp 1 and 9", locked, half_period); end
        base = pv_val.size();
        tog_gap(10);
        @(negedge clock);
        @(negedge clock);
        enable = 1'b0;
        settle(8);
        assert_cnt++; if (pv_val.size() !== base) begin fail_cnt++; $display("FAIL drop_no_pv got=%0d exp=0", pv_val.size() - base); end
        assert_cnt++; if (locked !== 1'b0) begin fail_cnt++; $display("FAIL drop_locked got=%0b exp=0", locked); end
        assert_cnt++; if (half_period !== 26'd9 || timeout !== 1'b0) begin fail_cnt++; $display("FAIL drop_retain hp=%0d timeout=%0b exp 9 and 0", half_period, timeout); end
        assert_cnt++; if (dut.state_reg !== IDLE) begin fail_cnt++; $display("FAIL drop_state got=%0d exp=%0d", dut.state_reg, IDLE); end
        enable = 1'b1;
        tog_gap(20);                            // arms only
        settle(6);
        assert_cnt++; if (pv_val.size() !== base) begin fail_cnt++; $display("FAIL reenable_arm new_pv=%0d exp=0", pv_val.size() - base); end
        tog_gap(30);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 1 || half_period !== 26'd29) begin fail_cnt++; $display("FAIL reenable_measure new_pv=%0d hp=%0d exp 1 and 29", pv_val.size() - base, half_period); end
    endtask

    // Reset asserted with counter at 37 while locked.
    task automatic test_reset_mid;
        int base;
        for (int i = 0; i < 6; i++) tog_gap(40);
        settle(3);
        for (int i = 0; i < 60 && dut.count_reg !== 26'd37; i++) @(negedge clock);
        assert_cnt++; if (dut.count_reg !== 26'd37 || locked !== 1'b1) begin fail_cnt++; $display("FAIL mid_pre count=%0d locked=%0b exp 37 and 1", dut.count_reg, locked); end
        reset = 1'b1;
        sig_in = 1'b0;
        @(negedge clock);
        assert_cnt++;
        if (half_period !== 26'd0 || period_valid !== 1'b0 || timeout !== 1'b0 || locked !== 1'b0) begin
            fail_cnt++; $display("FAIL mid_reset_outputs hp=%0d pv=%0b to=%0b lk=%0b exp all 0", half_period, period_valid, timeout, locked);
        end
        assert_cnt++; if (dut.state_reg !== IDLE || dut.count_reg !== 26'd0) begin fail_cnt++; $display("FAIL mid_reset_state state=%0d count=%0d exp %0d and 0", dut.state_reg, dut.count_reg, IDLE); end
        reset = 1'b0;
        last_tog = cyc;
        base = pv_val.size();
        tog_gap(10);
        tog_gap(30);
        settle(5);
        assert_cnt++; if (pv_val.size() - base !== 1 || half_period !== 26'd29) begin fail_cnt++; $display("FAIL mid_after new_pv=%0d hp=%0d exp 1 and 29", pv_val.size() - base, half_period); end
        assert_cnt++; if (hp_err !== 0) begin fail_cnt++; $display("FAIL hp_only_with_pv stray_changes=%0d exp=0", hp_err); end
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_jitter_step;
        test_timeout;
        test_boundary;
        test_enable_drop;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
